// File: rtl/hazard_control_unit_if.sv
// rtl/hazard_control_unit_if.sv - pipeline <-> hazard unit signal bundle
// Purpose: groups the hazard detection inputs and pipeline control outputs.
// Ports (signals):
//   id_rs/id_rt/id_uses_rt        IF/ID operand info
//   ex_mem_read/ex_rt             load in ID/EX
//   mem_branch_taken/mem_access/mem_ready  EX/MEM branch and memory status
//   pc_write, *_write, *_flush, *_bubble   pipeline register controls
//   state, stall_count, flush_count, mem_timeout  debug status
//   modport master: pipeline side, slave: hazard unit side
interface hazard_control_unit_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rt;
  logic             mem_branch_taken;
  logic             mem_access;
  logic             mem_ready;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_write;
  logic             id_ex_bubble;
  logic             ex_mem_write;
  logic             ex_mem_flush;
  logic             mem_wb_bubble;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic             mem_timeout;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           mem_branch_taken, mem_access, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
           ex_mem_write, ex_mem_flush, mem_wb_bubble,
           state, stall_count, flush_count, mem_timeout
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           mem_branch_taken, mem_access, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
           ex_mem_write, ex_mem_flush, mem_wb_bubble,
           state, stall_count, flush_count, mem_timeout
  );
endinterface

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use / branch-flush / memory-wait sequencer
// Purpose: drives PC and pipeline register controls of the 5-stage core and
//   keeps a small state machine plus saturating debug counters.
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  synchronous reset, active high
//   bus   slave modport of hazard_control_unit_if (hazard inputs, control
//         outputs, state, stall_count, flush_count, mem_timeout)
module hazard_control_unit #(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  hazard_control_unit_if.slave  bus
);
  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_LOAD_STALL = 2'd1,
    S_MEM_WAIT   = 2'd2,
    S_FLUSH      = 2'd3
  } state_t;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_stall_count;
  logic [CNT_W-1:0]  r_flush_count;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_mem_timeout;

  logic w_memwait;
  logic w_flush;
  logic w_loaduse;
  logic w_dep;

  // Events are mutually exclusive: memory wait beats branch flush beats load-use.
  assign w_dep     = (bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt));
  assign w_memwait = bus.mem_access && !bus.mem_ready;
  assign w_flush   = bus.mem_branch_taken && !w_memwait;
  assign w_loaduse = bus.ex_mem_read && (bus.ex_rt != '0) && w_dep && !w_memwait && !bus.mem_branch_taken;

  always_comb begin
    bus.pc_write      = 1'b1;
    bus.if_id_write   = 1'b1;
    bus.if_id_flush   = 1'b0;
    bus.id_ex_write   = 1'b1;
    bus.id_ex_bubble  = 1'b0;
    bus.ex_mem_write  = 1'b1;
    bus.ex_mem_flush  = 1'b0;
    bus.mem_wb_bubble = 1'b0;
    if (rst) begin
      bus.pc_write      = 1'b0;
      bus.if_id_write   = 1'b0;
      bus.id_ex_write   = 1'b0;
      bus.ex_mem_write  = 1'b0;
      bus.if_id_flush   = 1'b1;
      bus.id_ex_bubble  = 1'b1;
      bus.ex_mem_flush  = 1'b1;
      bus.mem_wb_bubble = 1'b1;
    end else if (w_memwait) begin
      // Freeze everything upstream of MEM; WB receives a bubble each wait cycle.
      bus.pc_write      = 1'b0;
      bus.if_id_write   = 1'b0;
      bus.id_ex_write   = 1'b0;
      bus.ex_mem_write  = 1'b0;
      bus.mem_wb_bubble = 1'b1;
    end else if (w_flush) begin
      bus.if_id_flush   = 1'b1;
      bus.id_ex_bubble  = 1'b1;
      bus.ex_mem_flush  = 1'b1;
    end else if (w_loaduse) begin
      bus.pc_write      = 1'b0;
      bus.if_id_write   = 1'b0;
      bus.id_ex_bubble  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_RUN;
      r_stall_count <= '0;
      r_flush_count <= '0;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      if (w_memwait)      r_state <= S_MEM_WAIT;
      else if (w_flush)   r_state <= S_FLUSH;
      else if (w_loaduse) r_state <= S_LOAD_STALL;
      else                r_state <= S_RUN;

      if ((w_memwait || w_loaduse) && (r_stall_count != '1))
        r_stall_count <= r_stall_count + CNT_W'(1);
      if (w_flush && (r_flush_count != '1))
        r_flush_count <= r_flush_count + CNT_W'(1);

      // Wait counter saturates at MEM_TIMEOUT so a long stall never wraps it.
      if (w_memwait) begin
        if (r_wait_cnt != WAIT_W'(MEM_TIMEOUT))
          r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        if (r_wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1))
          r_mem_timeout <= 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  assign bus.state       = r_state;
  assign bus.stall_count = r_stall_count;
  assign bus.flush_count = r_flush_count;
  assign bus.mem_timeout = r_mem_timeout;
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - self-checking bench for hazard_control_unit
module tb_hazard_control_unit;
  localparam int REG_W   = 5;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Control vector order: pc_write, if_id_write, if_id_flush, id_ex_write,
  // id_ex_bubble, ex_mem_write, ex_mem_flush, mem_wb_bubble
  localparam logic [7:0] C_RST   = 8'b00101011;
  localparam logic [7:0] C_RUN   = 8'b11010100;
  localparam logic [7:0] C_WAIT  = 8'b00000001;
  localparam logic [7:0] C_FLUSH = 8'b11111110;
  localparam logic [7:0] C_LU    = 8'b00011100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  int m_state, m_stall, m_flush, m_wait;
  bit m_timeout;

  hazard_control_unit_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hif ();

  hazard_control_unit #(.REG_W(REG_W), .MEM_TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] w_ctl;
  assign w_ctl = {hif.pc_write, hif.if_id_write, hif.if_id_flush, hif.id_ex_write,
                  hif.id_ex_bubble, hif.ex_mem_write, hif.ex_mem_flush, hif.mem_wb_bubble};

  function automatic bit ev_memwait();
    return hif.mem_access && !hif.mem_ready;
  endfunction

  function automatic bit ev_loaduse();
    return hif.ex_mem_read && (hif.ex_rt != 0) &&
           ((hif.ex_rt == hif.id_rs) || (hif.id_uses_rt && (hif.ex_rt == hif.id_rt)));
  endfunction

  function automatic logic [7:0] model_ctl();
    if (rst)                       return C_RST;
    if (ev_memwait())              return C_WAIT;
    if (hif.mem_branch_taken)      return C_FLUSH;
    if (ev_loaduse())              return C_LU;
    return C_RUN;
  endfunction

  task automatic model_advance();
    if (rst) begin
      m_state = 0; m_stall = 0; m_flush = 0; m_wait = 0; m_timeout = 0;
    end else if (ev_memwait()) begin
      m_state = 2;
      m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
      m_wait  = m_wait + 1;
      if (m_wait >= TIMEOUT) m_timeout = 1;
    end else begin
      m_wait = 0;
      if (hif.mem_branch_taken) begin
        m_state = 3;
        m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : m_flush;
      end else if (ev_loaduse()) begin
        m_state = 1;
        m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
      end else begin
        m_state = 0;
      end
    end
  endtask

  task automatic set_in(input bit r, input bit acc, input bit rdy, input bit br,
                        input bit mrd, input int ert, input int irs, input int irt,
                        input bit urt);
    @(negedge clk);
    rst                  = r;
    hif.mem_access       = acc;
    hif.mem_ready        = rdy;
    hif.mem_branch_taken = br;
    hif.ex_mem_read      = mrd;
    hif.ex_rt            = REG_W'(ert);
    hif.id_rs            = REG_W'(irs);
    hif.id_rt            = REG_W'(irt);
    hif.id_uses_rt       = urt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic do_reset();
    set_in(1, 0, 1, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset();
    set_in(1, 1, 0, 1, 1, 3, 3, 3, 1);
    n_checks++; if (w_ctl !== C_RST) begin n_errors++; $display("FAIL reset_ctl: got %b expected %b", w_ctl, C_RST); end
    tick();
    n_checks++; if (hif.state !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", hif.state); end
    n_checks++; if (hif.stall_count !== '0 || hif.flush_count !== '0 || hif.mem_timeout !== 1'b0) begin
      n_errors++; $display("FAIL reset_regs: got stall=%0d flush=%0d to=%b expected 0 0 0", hif.stall_count, hif.flush_count, hif.mem_timeout); end
    set_in(0, 0, 1, 0, 0, 0, 0, 0, 0);
    n_checks++; if (w_ctl !== C_RUN) begin n_errors++; $display("FAIL idle_ctl: got %b expected %b", w_ctl, C_RUN); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(0, 0, 1, 0, 1, 2, 2, 4, 1);
    n_checks++; if (w_ctl !== C_LU) begin n_errors++; $display("FAIL loaduse_ctl: got %b expected %b", w_ctl, C_LU); end
    tick();
    n_checks++; if (hif.state !== 2'd1 || hif.stall_count !== CNT_W'(1)) begin
      n_errors++; $display("FAIL loaduse_state: got state=%0d stall=%0d expected 1 1", hif.state, hif.stall_count); end
    set_in(0, 0, 1, 0, 0, 0, 3, 2, 1);
    n_checks++; if (w_ctl !== C_RUN) begin n_errors++; $display("FAIL loaduse_release: got %b expected %b", w_ctl, C_RUN); end
    tick();
    n_checks++; if (hif.state !== 2'd0 || hif.stall_count !== CNT_W'(1)) begin
      n_errors++; $display("FAIL loaduse_after: got state=%0d stall=%0d expected 0 1", hif.state, hif.stall_count); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    set_in(0, 0, 1, 0, 1, 0, 0, 0, 1);
    n_checks++; if (w_ctl !== C_RUN) begin n_errors++; $display("FAIL zero_reg_ctl: got %b expected %b", w_ctl, C_RUN); end
    tick();
    n_checks++; if (hif.state !== 2'd0 || hif.stall_count !== '0) begin
      n_errors++; $display("FAIL zero_reg_state: got state=%0d stall=%0d expected 0 0", hif.state, hif.stall_count); end
  endtask

  task automatic test_uses_rt();
    do_reset();
    set_in(0, 0, 1, 0, 1, 5, 7, 5, 0);
    n_checks++; if (w_ctl !== C_RUN) begin n_errors++; $display("FAIL rt_unused_ctl: got %b expected %b", w_ctl, C_RUN); end
    tick();
    set_in(0, 0, 1, 0, 1, 5, 7, 5, 1);
    n_checks++; if (w_ctl !== C_LU) begin n_errors++; $display("FAIL rt_used_ctl: got %b expected %b", w_ctl, C_LU); end
    tick();
    n_checks++; if (hif.stall_count !== CNT_W'(1)) begin n_errors++; $display("FAIL rt_used_stall: got %0d expected 1", hif.stall_count); end
  endtask

  task automatic test_flush_priority();
    do_reset();
    set_in(0, 0, 1, 1, 1, 2, 2, 0, 0);
    n_checks++; if (w_ctl !== C_FLUSH) begin n_errors++; $display("FAIL flush_ctl: got %b expected %b", w_ctl, C_FLUSH); end
    tick();
    n_checks++; if (hif.state !== 2'd3 || hif.flush_count !== CNT_W'(1) || hif.stall_count !== '0) begin
      n_errors++; $display("FAIL flush_state: got state=%0d flush=%0d stall=%0d expected 3 1 0", hif.state, hif.flush_count, hif.stall_count); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_in(0, 1, 0, 1, 1, 2, 2, 0, 0);
      n_checks++; if (w_ctl !== C_WAIT) begin n_errors++; $display("FAIL memwait_ctl[%0d]: got %b expected %b", k, w_ctl, C_WAIT); end
      tick();
      n_checks++; if (hif.state !== 2'd2) begin n_errors++; $display("FAIL memwait_state[%0d]: got %0d expected 2", k, hif.state); end
    end
    n_checks++; if (hif.stall_count !== CNT_W'(3) || hif.flush_count !== '0) begin
      n_errors++; $display("FAIL memwait_count: got stall=%0d flush=%0d expected 3 0", hif.stall_count, hif.flush_count); end
    set_in(0, 1, 1, 1, 0, 0, 0, 0, 0);
    n_checks++; if (w_ctl !== C_FLUSH) begin n_errors++; $display("FAIL ready_flush_ctl: got %b expected %b", w_ctl, C_FLUSH); end
    tick();
    n_checks++; if (hif.state !== 2'd3 || hif.flush_count !== CNT_W'(1)) begin
      n_errors++; $display("FAIL ready_flush_state: got state=%0d flush=%0d expected 3 1", hif.state, hif.flush_count); end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      n_checks++; if (hif.mem_timeout !== (k >= TIMEOUT)) begin
        n_errors++; $display("FAIL timeout_wait[%0d]: got %b expected %b", k, hif.mem_timeout, (k >= TIMEOUT)); end
    end
    set_in(0, 1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    n_checks++; if (hif.mem_timeout !== 1'b1 || hif.state !== 2'd0 || hif.stall_count !== CNT_W'(20)) begin
      n_errors++; $display("FAIL timeout_hold: got to=%b state=%0d stall=%0d expected 1 0 20", hif.mem_timeout, hif.state, hif.stall_count); end
    do_reset();
    n_checks++; if (hif.mem_timeout !== 1'b0) begin n_errors++; $display("FAIL timeout_clear: got %b expected 0", hif.mem_timeout); end
  endtask

  task automatic test_rst_midwait();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    set_in(1, 1, 0, 1, 0, 0, 0, 0, 0);
    n_checks++; if (w_ctl !== C_RST) begin n_errors++; $display("FAIL midwait_rst_ctl: got %b expected %b", w_ctl, C_RST); end
    tick();
    set_in(0, 0, 1, 0, 0, 0, 0, 0, 0);
    n_checks++; if (w_ctl !== C_RUN || hif.state !== 2'd0 || hif.stall_count !== '0 || hif.flush_count !== '0) begin
      n_errors++; $display("FAIL midwait_rst_after: got ctl=%b state=%0d stall=%0d flush=%0d expected %b 0 0 0",
                          w_ctl, hif.state, hif.stall_count, hif.flush_count, C_RUN); end
    tick();
  endtask

  task automatic test_random();
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) == 1);
      exp = model_ctl();
      n_checks++; if (w_ctl !== exp) begin n_errors++; $display("FAIL rand_ctl[%0d]: got %b expected %b", i, w_ctl, exp); end
      tick();
      n_checks++; if (hif.state !== 2'(m_state) || hif.stall_count !== CNT_W'(m_stall) ||
                      hif.flush_count !== CNT_W'(m_flush) || hif.mem_timeout !== m_timeout) begin
        n_errors++; $display("FAIL rand_regs[%0d]: got state=%0d stall=%0d flush=%0d to=%b expected %0d %0d %0d %b",
                            i, hif.state, hif.stall_count, hif.flush_count, hif.mem_timeout,
                            m_state, m_stall, m_flush, m_timeout); end
    end
  endtask

  initial begin
    m_state = 0; m_stall = 0; m_flush = 0; m_wait = 0; m_timeout = 0;
    hif.mem_access = 0; hif.mem_ready = 1; hif.mem_branch_taken = 0; hif.ex_mem_read = 0;
    hif.ex_rt = '0; hif.id_rs = '0; hif.id_rt = '0; hif.id_uses_rt = 0;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_uses_rt();
    test_flush_priority();
    test_mem_wait();
    test_timeout();
    test_rst_midwait();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
